// File: rtl/reaction_game_n.sv
// rtl/reaction_game_n.sv - N-player reaction-time game controller
// Optional READY timeout into NOCONTEST enabled by defining REACT_TIMEOUT_EN.
module reaction_game_n #(
  parameter int NUM_PLAYERS    = 4,
  parameter int SCORE_W        = 4,
  parameter int WIN_SCORE      = 5,
  parameter int DELAY_W        = 10,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           NEXT_N,
  input  logic [NUM_PLAYERS-1:0]         PLAYER_N,
  input  logic [DELAY_W-1:0]             DELAY,
  output logic                           SIGNAL,
  output logic [NUM_PLAYERS*SCORE_W-1:0] SCORES,
  output logic [2:0]                     WINNER,
  output logic                           WINNER_VALID,
  output logic                           FALSE_START,
  output logic [3:0]                     STATE
);

  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_A  = (DELAY_W > LOCK_W) ? DELAY_W : LOCK_W;
  localparam int CNT_W  = (CNT_A > TO_W) ? CNT_A : TO_W;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WAIT      = 4'd1,
    CUE       = 4'd2,
    READY     = 4'd3,
    FAULT     = 4'd4,
    HIT       = 4'd5,
    ROUND_END = 4'd6,
    GAME_OVER = 4'd7,
    NOCONTEST = 4'd8
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [SCORE_W-1:0]       score [NUM_PLAYERS];
  logic [2:0]               winner_q;
  logic                     hit_q;
  logic                     fault_q;

  logic [NUM_PLAYERS-1:0]   pressed;
  logic                     any_press;
  logic [2:0]               press_idx;
  logic                     any_win;
  logic [2:0]               win_idx;
  logic [CNT_W-1:0]         delay_load;

  assign pressed    = ~PLAYER_N;
  assign any_press  = |pressed;
  assign delay_load = (DELAY == '0) ? CNT_W'(1) : CNT_W'(DELAY);

  // Descending scan so the lowest index wins ties.
  always_comb begin
    press_idx = '0;
    win_idx   = '0;
    any_win   = 1'b0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (pressed[i]) press_idx = 3'(i);
      if (score[i] == SCORE_W'(WIN_SCORE)) begin
        win_idx = 3'(i);
        any_win = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      winner_q <= '0;
      hit_q    <= 1'b0;
      fault_q  <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
    end else begin
      case (state)
        IDLE: if (!NEXT_N) begin
          state <= WAIT;
          cnt   <= delay_load;
        end
        WAIT: if (any_press) begin
          state    <= FAULT;
          winner_q <= press_idx;
          fault_q  <= 1'b1;
        end else if (cnt <= CNT_W'(1)) begin
          state <= CUE;
          cnt   <= CNT_W'(LOCKOUT_CYCLES);
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        CUE: if (any_press) begin
          state    <= FAULT;
          winner_q <= press_idx;
          fault_q  <= 1'b1;
        end else if (cnt <= CNT_W'(1)) begin
          state <= READY;
          cnt   <= CNT_W'(TIMEOUT_CYCLES);
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        READY: if (any_press) begin
          state    <= HIT;
          winner_q <= press_idx;
          hit_q    <= 1'b1;
        end
`ifdef REACT_TIMEOUT_EN
        else if (cnt <= CNT_W'(1)) begin
          state <= NOCONTEST;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
`endif
        FAULT: begin
          state <= ROUND_END;
          for (int i = 0; i < NUM_PLAYERS; i++)
            if (3'(i) != winner_q && score[i] != SCORE_W'(WIN_SCORE))
              score[i] <= score[i] + SCORE_W'(1);
        end
        HIT: begin
          state <= ROUND_END;
          for (int i = 0; i < NUM_PLAYERS; i++)
            if (3'(i) == winner_q && score[i] != SCORE_W'(WIN_SCORE))
              score[i] <= score[i] + SCORE_W'(1);
        end
        NOCONTEST: state <= ROUND_END;
        ROUND_END: if (any_win) begin
          state    <= GAME_OVER;
          winner_q <= win_idx;
        end else if (!NEXT_N) begin
          state   <= WAIT;
          cnt     <= delay_load;
          hit_q   <= 1'b0;
          fault_q <= 1'b0;
        end
        GAME_OVER: state <= GAME_OVER;
        default:   state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
    assign SCORES[g*SCORE_W +: SCORE_W] = score[g];
  end

  assign STATE        = state;
  assign SIGNAL       = (state == CUE) || (state == READY);
  assign WINNER       = winner_q;
  assign WINNER_VALID = (state == GAME_OVER) || (state == ROUND_END && hit_q);
  assign FALSE_START  = fault_q &&
                        (state == FAULT || state == ROUND_END || state == GAME_OVER);

endmodule

// File: tb/tb_reaction_game_n.sv
// tb/tb_reaction_game_n.sv - directed self-checking bench for reaction_game_n
module tb_reaction_game_n;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        NEXT_N = 1'b1;
  logic [3:0]  PLAYER_N = 4'hF;
  logic [9:0]  DELAY = 10'd0;
  logic        SIGNAL;
  logic [15:0] SCORES;
  logic [2:0]  WINNER;
  logic        WINNER_VALID;
  logic        FALSE_START;
  logic [3:0]  STATE;

  int checks = 0;
  int errors = 0;

  reaction_game_n #(
    .NUM_PLAYERS(4), .SCORE_W(4), .WIN_SCORE(5), .DELAY_W(10),
    .LOCKOUT_CYCLES(8), .TIMEOUT_CYCLES(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .NEXT_N(NEXT_N), .PLAYER_N(PLAYER_N), .DELAY(DELAY),
    .SIGNAL(SIGNAL), .SCORES(SCORES), .WINNER(WINNER), .WINNER_VALID(WINNER_VALID),
    .FALSE_START(FALSE_START), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; tick(); tick();
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", STATE); end
    checks++; if (SCORES !== 16'h0000) begin errors++; $display("FAIL reset_scores: got %h expected 0000", SCORES); end
    checks++; if ({SIGNAL, WINNER_VALID, FALSE_START, WINNER} !== 6'b000000) begin errors++; $display("FAIL reset_outs: got %b expected 000000", {SIGNAL, WINNER_VALID, FALSE_START, WINNER}); end
    RESET = 1'b0;
  endtask

  task automatic test_hit_round();
    NEXT_N = 1'b0; DELAY = 10'd3; tick(); NEXT_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL wait_len cycle %0d: got %0d expected 1", k, STATE); end
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      checks++; if (STATE !== 4'd2 || SIGNAL !== 1'b1) begin errors++; $display("FAIL cue_len cycle %0d: got state %0d sig %b expected 2/1", k, STATE, SIGNAL); end
      tick();
    end
    checks++; if (STATE !== 4'd3 || SIGNAL !== 1'b1) begin errors++; $display("FAIL ready: got state %0d sig %b expected 3/1", STATE, SIGNAL); end
    PLAYER_N = 4'b1011; tick(); PLAYER_N = 4'hF;
    checks++; if (STATE !== 4'd5 || SIGNAL !== 1'b0) begin errors++; $display("FAIL hit_state: got %0d sig %b expected 5/0", STATE, SIGNAL); end
    tick();
    checks++; if (STATE !== 4'd6) begin errors++; $display("FAIL hit_round_end: got %0d expected 6", STATE); end
    checks++; if (SCORES !== 16'h0100) begin errors++; $display("FAIL hit_scores: got %h expected 0100", SCORES); end
    checks++; if (WINNER !== 3'd2 || WINNER_VALID !== 1'b1 || FALSE_START !== 1'b0) begin errors++; $display("FAIL hit_winner: got %0d v%b f%b expected 2 v1 f0", WINNER, WINNER_VALID, FALSE_START); end
  endtask

  task automatic test_false_start_wait();
    NEXT_N = 1'b0; DELAY = 10'd10; tick(); NEXT_N = 1'b1;
    checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL fsw_wait: got %0d expected 1", STATE); end
    PLAYER_N = 4'b1101; tick(); PLAYER_N = 4'hF;
    checks++; if (STATE !== 4'd4 || FALSE_START !== 1'b1 || SIGNAL !== 1'b0) begin errors++; $display("FAIL fsw_fault: got %0d fs%b sig%b expected 4 fs1 sig0", STATE, FALSE_START, SIGNAL); end
    tick();
    checks++; if (SCORES !== 16'h1201) begin errors++; $display("FAIL fsw_scores: got %h expected 1201", SCORES); end
    checks++; if (STATE !== 4'd6 || FALSE_START !== 1'b1 || WINNER_VALID !== 1'b0) begin errors++; $display("FAIL fsw_round_end: got %0d fs%b v%b expected 6 fs1 v0", STATE, FALSE_START, WINNER_VALID); end
  endtask

  task automatic test_false_start_cue();
    NEXT_N = 1'b0; DELAY = 10'd1; tick(); NEXT_N = 1'b1;
    tick();
    repeat (4) tick();
    checks++; if (STATE !== 4'd2) begin errors++; $display("FAIL fsc_cue5: got %0d expected 2", STATE); end
    PLAYER_N = 4'b0111; tick(); PLAYER_N = 4'hF;
    checks++; if (STATE !== 4'd4) begin errors++; $display("FAIL fsc_fault: got %0d expected 4", STATE); end
    tick();
    checks++; if (SCORES !== 16'h1312 || FALSE_START !== 1'b1) begin errors++; $display("FAIL fsc_scores: got %h fs%b expected 1312 fs1", SCORES, FALSE_START); end
  endtask

  task automatic test_simultaneous();
    NEXT_N = 1'b0; DELAY = 10'd0; tick(); NEXT_N = 1'b1;
    checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL zero_delay_wait: got %0d expected 1", STATE); end
    tick();
    checks++; if (STATE !== 4'd2) begin errors++; $display("FAIL zero_delay_cue: got %0d expected 2", STATE); end
    repeat (8) tick();
    checks++; if (STATE !== 4'd3) begin errors++; $display("FAIL simul_ready: got %0d expected 3", STATE); end
    PLAYER_N = 4'b0101; tick(); PLAYER_N = 4'hF; tick();
    checks++; if (SCORES !== 16'h1322) begin errors++; $display("FAIL simul_scores: got %h expected 1322", SCORES); end
    checks++; if (WINNER !== 3'd1 || WINNER_VALID !== 1'b1 || FALSE_START !== 1'b0) begin errors++; $display("FAIL simul_winner: got %0d v%b f%b expected 1 v1 f0", WINNER, WINNER_VALID, FALSE_START); end
  endtask

  task automatic test_game_over();
    logic [15:0] exp;
    for (int k = 0; k < 3; k++) begin
      NEXT_N = 1'b0; DELAY = 10'd1; tick(); NEXT_N = 1'b1;
      tick(); repeat (8) tick();
      PLAYER_N = 4'b1110; tick(); PLAYER_N = 4'hF; tick();
      exp = 16'h1323 + 16'(k);
      checks++; if (STATE !== 4'd6 || SCORES !== exp) begin errors++; $display("FAIL go_round %0d: got %0d %h expected 6 %h", k, STATE, SCORES, exp); end
    end
    tick();
    checks++; if (STATE !== 4'd7 || WINNER !== 3'd0 || WINNER_VALID !== 1'b1 || FALSE_START !== 1'b0) begin errors++; $display("FAIL go_state: got %0d w%0d v%b f%b expected 7 w0 v1 f0", STATE, WINNER, WINNER_VALID, FALSE_START); end
    NEXT_N = 1'b0; PLAYER_N = 4'h0; repeat (5) tick();
    checks++; if (STATE !== 4'd7 || SCORES !== 16'h1325 || SIGNAL !== 1'b0) begin errors++; $display("FAIL go_hold: got %0d %h sig%b expected 7 1325 sig0", STATE, SCORES, SIGNAL); end
    RESET = 1'b1; tick(); RESET = 1'b0; NEXT_N = 1'b1; PLAYER_N = 4'hF;
    checks++; if (STATE !== 4'd0 || SCORES !== 16'h0000 || WINNER_VALID !== 1'b0) begin errors++; $display("FAIL go_reset: got %0d %h v%b expected 0 0000 v0", STATE, SCORES, WINNER_VALID); end
  endtask

  task automatic test_fault_win();
    logic [3:0] who;
    for (int k = 0; k < 5; k++) begin
      NEXT_N = 1'b0; DELAY = 10'd5; tick(); NEXT_N = 1'b1;
      who = (k < 4) ? 4'b1110 : 4'b0111;
      PLAYER_N = who; tick(); PLAYER_N = 4'hF; tick();
      checks++; if (STATE !== 4'd6 || FALSE_START !== 1'b1) begin errors++; $display("FAIL fw_round %0d: got %0d fs%b expected 6 fs1", k, STATE, FALSE_START); end
    end
    checks++; if (SCORES !== 16'h4551) begin errors++; $display("FAIL fw_scores: got %h expected 4551", SCORES); end
    tick();
    checks++; if (STATE !== 4'd7 || WINNER !== 3'd1 || FALSE_START !== 1'b1 || WINNER_VALID !== 1'b1) begin errors++; $display("FAIL fw_game_over: got %0d w%0d f%b v%b expected 7 w1 f1 v1", STATE, WINNER, FALSE_START, WINNER_VALID); end
  endtask

  task automatic test_reset_mid();
    RESET = 1'b1; tick(); RESET = 1'b0;
    NEXT_N = 1'b0; DELAY = 10'd2; tick(); NEXT_N = 1'b1;
    tick(); tick();
    checks++; if (STATE !== 4'd2 || SIGNAL !== 1'b1) begin errors++; $display("FAIL rm_cue: got %0d sig%b expected 2 sig1", STATE, SIGNAL); end
    RESET = 1'b1; NEXT_N = 1'b0; PLAYER_N = 4'h0; tick();
    checks++; if (STATE !== 4'd0 || SIGNAL !== 1'b0 || SCORES !== 16'h0000) begin errors++; $display("FAIL rm_reset: got %0d sig%b %h expected 0 sig0 0000", STATE, SIGNAL, SCORES); end
    RESET = 1'b0; NEXT_N = 1'b1; PLAYER_N = 4'hF;
  endtask

`ifdef REACT_TIMEOUT_EN
  task automatic test_timeout();
    NEXT_N = 1'b0; DELAY = 10'd1; tick(); NEXT_N = 1'b1;
    tick(); repeat (8) tick();
    repeat (3) tick();
    checks++; if (STATE !== 4'd3) begin errors++; $display("FAIL to_ready: got %0d expected 3", STATE); end
    tick();
    checks++; if (STATE !== 4'd8 || SIGNAL !== 1'b0) begin errors++; $display("FAIL to_nocontest: got %0d sig%b expected 8 sig0", STATE, SIGNAL); end
    tick();
    checks++; if (STATE !== 4'd6 || WINNER_VALID !== 1'b0 || FALSE_START !== 1'b0 || SCORES !== 16'h0000) begin errors++; $display("FAIL to_round_end: got %0d v%b f%b %h expected 6 v0 f0 0000", STATE, WINNER_VALID, FALSE_START, SCORES); end
  endtask
`endif

  initial begin
    test_reset();
    test_hit_round();
    test_false_start_wait();
    test_false_start_cue();
    test_simultaneous();
    test_game_over();
    test_fault_win();
    test_reset_mid();
`ifdef REACT_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reaction_game_n.md
# reaction_game_n

N-player reaction-time game controller: after a pseudo-random delay it raises a cue, penalises any player who presses during the delay or lockout window, and awards a point to the first player who presses once the cue is live. It sits at the lab top level between the debounced player buttons and an external delay source (address generator plus lookup) and the score/winner display drivers. It generalises the two-player game to `NUM_PLAYERS` channels with a configurable winning score and lockout window.

## Interface
- `NUM_PLAYERS`, 4: number of player buttons; range 2..8.
- `SCORE_W`, 4: bits per player score.
- `WIN_SCORE`, 5: score that ends the game; must be < 2^`SCORE_W`.
- `DELAY_W`, 10: width of the random delay input.
- `LOCKOUT_CYCLES`, 8: cycles of cue-on during which a press is still a false start; must be ≥ 1.
- `TIMEOUT_CYCLES`, 1023: READY timeout, used only with `REACT_TIMEOUT_EN`.

Ports:
- `CLK`  in  1  clock.
- `RESET`  in  1  synchronous, active-high; clock `CLK`.
- `NEXT_N`  in  1  active-low "start round" button.
- `PLAYER_N`  in  `NUM_PLAYERS`  active-low player buttons; bit i is player i.
- `DELAY`  in  `DELAY_W`  random delay in cycles, sampled on entry to WAIT.
- `SIGNAL`  out  1  cue LED.
- `SCORES`  out  `NUM_PLAYERS*SCORE_W`  player i's score in bits [i*`SCORE_W` +: `SCORE_W`].
- `WINNER`  out  3  index of the round or game winner; valid only when `WINNER_VALID` is high.
- `WINNER_VALID`  out  1  high in ROUND_END after a HIT, and in GAME_OVER.
- `FALSE_START`  out  1  high in FAULT, and in ROUND_END or GAME_OVER following a FAULT.
- `STATE`  out  4  current state encoding.

## Operation
States and encodings: IDLE=0, WAIT=1, CUE=2, READY=3, FAULT=4, HIT=5, ROUND_END=6, GAME_OVER=7, NOCONTEST=8.

Transitions:
- IDLE → WAIT when `NEXT_N`=0.
- WAIT: on entry, load the delay counter with `DELAY`, treating 0 as 1.
  - Any press → FAULT.
  - Counter reaches 0 → CUE.
- CUE: `SIGNAL`=1 for exactly `LOCKOUT_CYCLES` cycles.
  - Any press → FAULT.
  - Otherwise → READY.
- READY: `SIGNAL`=1.
  - Any press → HIT.
- FAULT: latch the offender index, then → ROUND_END. Every player except the offender gets +1.
- HIT: latch the presser index, then → ROUND_END. That player gets +1.
- ROUND_END:
  - Any score == `WIN_SCORE` → GAME_OVER.
  - Otherwise, `NEXT_N`=0 → WAIT.
  - Otherwise hold.
- GAME_OVER: absorbing until `RESET`. `WINNER` is the lowest-index player with score == `WIN_SCORE`.

Rules:
- Simultaneous presses resolve to the lowest index.
- Scores saturate at `WIN_SCORE`; no wrap.
- A FAULT can bring several players to `WIN_SCORE` at once; the lowest index wins.
- `SIGNAL` is 1 only in CUE and READY.

Reset values: all scores 0, state IDLE, `SIGNAL`=0, `WINNER`=0, `WINNER_VALID`=0, `FALSE_START`=0.

## Timing
- Outputs are decoded from registered state and update one cycle after the input that causes a transition.
- WAIT lasts max(`DELAY`,1) cycles.
- Press-to-score latency: the press is seen in READY; HIT occupies the next cycle; the updated score is visible on the first cycle of ROUND_END (2 cycles after the sampled press).
- FAULT behaves the same way: scores update entering ROUND_END.
- `NEXT_N` held low across ROUND_END starts exactly one new round. A new round needs `NEXT_N` sampled low in ROUND_END; it is level-sensitive, with no edge detect.
- `RESET` mid-round forces IDLE and zeroes scores on the next edge, overriding all other inputs.

## Configuration
- `REACT_TIMEOUT_EN` defined:
  - READY counts cycles. After `TIMEOUT_CYCLES` cycles with no press → NOCONTEST.
  - NOCONTEST lasts one cycle with no score change and `SIGNAL`=0, then → ROUND_END with `WINNER_VALID`=0 and `FALSE_START`=0.
- `REACT_TIMEOUT_EN` undefined: READY waits indefinitely, and state 8 is unreachable.

## Test plan
- Reset, `NEXT_N`=0, `DELAY`=3, no presses → `STATE` 0→1 for 3 cycles→2 for 8 cycles→3 with `SIGNAL`=1; press player 2 → HIT, then ROUND_END with score2=1, `WINNER`=2, `WINNER_VALID`=1.
- Player 1 presses in WAIT → FAULT with `FALSE_START`=1; scores 0,2,3 go to 1 and score1 stays 0.
- Press during CUE cycle 5 → FAULT, not HIT.
- Players 1 and 3 press in the same READY cycle → only player 1 scores.
- Play 5 HITs for player 0 → GAME_OVER, `WINNER`=0, and state held despite `NEXT_N`/`PLAYER_N` activity; then `RESET` → all scores 0, IDLE.
- With `REACT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no press in READY → state 8 then 6, scores unchanged; `DELAY`=0 gives a 1-cycle WAIT.
